ct_stream_arb: RTL and testbench
================================

# ct_stream_arb

Packet-aware round-robin arbiter that merges NI valid/ready streams into one output stream ahead of a field-conversion stage in a GENIE interconnect. The grant is held for a whole packet, from first beat to EOP, and the winning input's index is emitted on o_field. The downstream converter can map that index to a destination or tag value. Zero-latency by default; an optional output register stage cuts the combinational ready/valid path.

## Interface
- NI, default 2: number of input streams, ≥1
- WD, default 8: passthrough data width per stream
- WS (localparam): source index width, max(1, $clog2(NI))

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- i_data  in  NI*WD  input data, stream k at [k*WD +: WD]
- i_eop  in  NI  end-of-packet flag per stream
- i_valid  in  NI  valid per stream
- o_ready  out  NI  ready per stream, one-hot or zero
- o_data  out  WD  granted stream's data
- o_field  out  WS  index of granted stream
- o_eop  out  1  granted stream's EOP
- o_valid  out  1  output valid
- i_ready  in  1  downstream ready

## Operation
- A beat transfers on an interface when its valid and ready are both high at the rising edge.
- The state machine has two states: IDLE and LOCKED. Registers are `state`, `grant` [WS] and `last` [WS].
- IDLE:
  - `sel` = first k with i_valid[k], searching cyclically from last+1 to last+NI (mod NI).
  - If no input is valid: o_valid=0 and o_ready=0.
  - If a beat is accepted with eop=0: go to LOCKED, grant<=sel.
  - If a beat is accepted with eop=1: stay in IDLE, last<=sel.
- LOCKED:
  - `sel`=grant. Only the grant input can pass; all other o_ready bits are 0.
  - On an accepted beat with eop=1: go to IDLE, last<=grant.
  - If i_valid[grant] drops mid-packet, output a bubble (o_valid=0) and keep the lock.
- Output muxing: o_data, o_eop and o_field come from `sel`. o_ready[sel]=i_ready; all other o_ready bits are 0.
- Index arithmetic is modulo NI. With a non-power-of-2 NI, wrap from NI-1 to 0 explicitly; never use unused code points.
- NI=1: o_field is always 0. The state machine still tracks EOP.

## Timing
- Reset values: state=IDLE, last=NI-1 (input 0 has first priority), grant=0, o_valid=0, o_ready=0.
- Reset asserted mid-packet aborts the lock immediately. Arbitration restarts from input 0.
- Without the output register: latency is 0 cycles.
  - o_valid and o_ready depend combinationally on i_valid, i_ready and the registered state.
  - o_ready must not depend on o_valid.
- A single-beat packet (eop=1 on its first beat) never enters LOCKED. Back-to-back single-beat packets from different inputs can transfer on consecutive cycles.
- When one input has every packet single-beat and others request, rotation guarantees every requester a grant within NI packets.
- If i_ready is low, `sel` stays stable in IDLE: `last` is unchanged, so the same requester is picked again.
- o_valid is never asserted combinationally from an input other than `sel`.

## Configuration
- CT_STREAM_ARB_OREG_EN defined: a 2-entry skid buffer is inserted after the mux.
  - o_data, o_field, o_eop and o_valid are registered, giving 1 cycle of latency.
  - Upstream ready is taken from the buffer's "not full" signal, which is registered. There is no combinational path from i_ready to o_ready.
  - Full-rate throughput is kept.
  - Arbitration state advances on upstream acceptance, not downstream acceptance.
  - Buffer outputs reset to 0.
- Not defined: purely combinational output path as described above.

## Structure
- Shared package ct_pkg holds:
  - `arb_state_t` enum: IDLE, LOCKED.
  - A `ct_wrap_inc` function for the modulo-NI increment.
- One sub-module, ct_rr_pick: a combinational rotating priority encoder. Inputs: req [NI], base [WS]. Outputs: sel [WS], any.
- The skid buffer sits inline under the macro. It is not a separate module.

## Test plan
- NI=3. Inputs 0, 1 and 2 each hold a 1-beat packet, i_ready=1 → o_field sequence 0,1,2 on cycles 0–2, o_ready one-hot each cycle.
- NI=2. Input 1 sends a 4-beat packet while input 0 is valid throughout → o_field=1 for 4 beats, o_ready[0]=0 throughout, then o_field=0 on the next cycle.
- Locked on input 0, i_valid[0] drops for 2 cycles mid-packet while input 1 is valid → o_valid=0 for 2 cycles, no beat from input 1 until input 0's EOP.
- i_ready held low 5 cycles with inputs 0 and 1 valid → o_field=0 stable, no transfer, `last` unchanged; when ready is released, input 0 transfers first.
- Reset pulled low for 1 cycle mid-packet on input 2 (NI=3) → o_valid=0 during reset; afterwards input 0 wins if valid, and no stale lock remains.
- CT_STREAM_ARB_OREG_EN defined, NI=2, continuous 1-beat packets, i_ready toggling 1,0,1,0 → no beat lost or duplicated, output lags by 1 cycle, and o_ready has no same-cycle response to i_ready.

Source files
------------

// File: rtl/ct_stream_arb_pkg.sv
// ----------------------------------------------------------------------------
// ct_pkg
//   Shared types and helpers for the packet-aware stream arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   - ct_wrap_inc : increment an index modulo n, wrapping n-1 -> 0 explicitly
//                   so that non-power-of-2 counts never reach unused codes.
// ----------------------------------------------------------------------------
package ct_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned ct_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
        if ((n <= 1) || (idx >= n - 1)) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/ct_stream_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// ct_rr_pick
//   Combinational rotating priority encoder. Searches req cyclically starting
//   at base+1 and ending at base (all modulo NI) and returns the first set bit.
//   Ports:
//     req  [NI]  request vector
//     base [WS]  index of the most recently served requester
//     sel  [WS]  chosen index (0 when nothing requests)
//     any        at least one request present
// ----------------------------------------------------------------------------
module ct_rr_pick
    import ct_pkg::*;
#(
    parameter int unsigned NI = 2,
    parameter int unsigned WS = 1
) (
    input  logic [NI-1:0] req,
    input  logic [WS-1:0] base,
    output logic [WS-1:0] sel,
    output logic          any
);

    always_comb begin : p_pick
        logic [WS-1:0] w_idx;
        sel   = '0;
        any   = 1'b0;
        w_idx = base;
        for (int unsigned i = 0; i < NI; i++) begin
            w_idx = WS'(ct_wrap_inc(32'(w_idx), NI));
            if (!any && req[w_idx]) begin
                sel = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_stream_arb.sv
// ----------------------------------------------------------------------------
// ct_stream_arb
//   Packet-aware round-robin arbiter merging NI valid/ready streams into one.
//   The grant is held from a packet's first beat until its EOP beat; the index
//   of the winning input is emitted on o_field.
//
//   Optional feature macro: CT_STREAM_ARB_OREG_EN
//     defined   : 2-entry skid buffer after the mux; outputs registered
//                 (1 cycle latency), upstream ready = registered "not full".
//     undefined : zero-latency combinational output path.
//
//   Ports:
//     clk      in   clock, rising edge
//     reset    in   asynchronous active-low reset
//     i_data   in   NI*WD  stream k data at [k*WD +: WD]
//     i_eop    in   NI     per-stream end of packet
//     i_valid  in   NI     per-stream valid
//     o_ready  out  NI     per-stream ready, one-hot or zero
//     o_data   out  WD     granted stream data
//     o_field  out  WS     granted stream index
//     o_eop    out  1      granted stream EOP
//     o_valid  out  1      output valid
//     i_ready  in   1      downstream ready
// ----------------------------------------------------------------------------
module ct_stream_arb
    import ct_pkg::*;
#(
    parameter  int unsigned NI = 2,
    parameter  int unsigned WD = 8,
    localparam int unsigned WS = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WD-1:0] i_data,
    input  logic [NI-1:0]    i_eop,
    input  logic [NI-1:0]    i_valid,
    output logic [NI-1:0]    o_ready,
    output logic [WD-1:0]    o_data,
    output logic [WS-1:0]    o_field,
    output logic             o_eop,
    output logic             o_valid,
    input  logic             i_ready
);

    arb_state_t    r_state;
    logic [WS-1:0] r_grant;
    logic [WS-1:0] r_last;

    logic [WS-1:0] w_pick_sel;
    logic          w_pick_any;
    logic [WS-1:0] w_sel;
    logic          w_sel_valid;
    logic          w_gate;
    logic          w_dn_ready;
    logic          w_acc;
    logic [WD-1:0] w_mux_data;
    logic          w_mux_eop;
    logic [NI-1:0] w_ready;

    ct_rr_pick #(
        .NI (NI),
        .WS (WS)
    ) u_pick (
        .req  (i_valid),
        .base (r_last),
        .sel  (w_pick_sel),
        .any  (w_pick_any)
    );

    // Reset also masks the combinational handshake so nothing is offered
    // or accepted while reset is held.
    always_comb begin
        w_sel       = (r_state == LOCKED) ? r_grant : w_pick_sel;
        w_gate      = reset & ((r_state == LOCKED) | w_pick_any);
        w_sel_valid = 1'b0;
        w_mux_data  = '0;
        w_mux_eop   = 1'b0;
        for (int unsigned k = 0; k < NI; k++) begin
            if (w_sel == WS'(k)) begin
                w_sel_valid = i_valid[k];
                w_mux_data  = i_data[k*WD +: WD];
                w_mux_eop   = i_eop[k];
            end
        end
        w_sel_valid = w_sel_valid & w_gate;
        w_acc       = w_sel_valid & w_dn_ready;
        w_ready     = '0;
        for (int unsigned k = 0; k < NI; k++) begin
            w_ready[k] = w_gate & w_dn_ready & (w_sel == WS'(k));
        end
    end

    assign o_ready = w_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= WS'(NI - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_mux_eop) begin
                            r_last <= w_sel;
                        end else begin
                            r_state <= LOCKED;
                            r_grant <= w_sel;
                        end
                    end
                end
                LOCKED: begin
                    if (w_acc && w_mux_eop) begin
                        r_state <= IDLE;
                        r_last  <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CT_STREAM_ARB_OREG_EN
    // Skid buffer: entry 0 drives the outputs, entry 1 absorbs the beat that
    // arrives while downstream stalls. Upstream ready only looks at r_v1.
    logic          r_v0, r_v1;
    logic [WD-1:0] r_d0, r_d1;
    logic [WS-1:0] r_f0, r_f1;
    logic          r_e0, r_e1;
    logic          w_push;
    logic          w_pop;

    assign w_dn_ready = ~r_v1;
    assign w_push     = w_acc;
    assign w_pop      = r_v0 & i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_f0 <= '0;
            r_f1 <= '0;
            r_e0 <= 1'b0;
            r_e1 <= 1'b0;
        end else begin
            if (w_push && w_pop) begin
                r_d0 <= w_mux_data;
                r_f0 <= w_sel;
                r_e0 <= w_mux_eop;
            end else if (w_pop) begin
                r_v0 <= r_v1;
                r_d0 <= r_d1;
                r_f0 <= r_f1;
                r_e0 <= r_e1;
                r_v1 <= 1'b0;
            end else if (w_push) begin
                if (!r_v0) begin
                    r_v0 <= 1'b1;
                    r_d0 <= w_mux_data;
                    r_f0 <= w_sel;
                    r_e0 <= w_mux_eop;
                end else begin
                    r_v1 <= 1'b1;
                    r_d1 <= w_mux_data;
                    r_f1 <= w_sel;
                    r_e1 <= w_mux_eop;
                end
            end
        end
    end

    assign o_valid = r_v0;
    assign o_data  = r_d0;
    assign o_field = r_f0;
    assign o_eop   = r_e0;
`else
    assign w_dn_ready = i_ready;
    assign o_valid    = w_sel_valid;
    assign o_data     = w_mux_data;
    assign o_field    = w_sel;
    assign o_eop      = w_mux_eop;
`endif

endmodule

// File: tb/tb_ct_stream_arb.sv
// ----------------------------------------------------------------------------
// tb_ct_stream_arb
//   Directed bench for ct_stream_arb with one NI=3 and one NI=2 instance.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   mid-cycle.
// ----------------------------------------------------------------------------
module tb_ct_stream_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // NI=3 instance
    logic [23:0] d3;
    logic [2:0]  e3, v3, r3;
    logic [7:0]  od3;
    logic [1:0]  of3;
    logic        oe3, ov3, ir3;

    // NI=2 instance
    logic [15:0] d2;
    logic [1:0]  e2, v2, r2;
    logic [7:0]  od2;
    logic [0:0]  of2;
    logic        oe2, ov2, ir2;

    int n_chk  = 0;
    int n_fail = 0;

    ct_stream_arb #(.NI(3), .WD(8)) u_dut3 (
        .clk(clk), .reset(reset), .i_data(d3), .i_eop(e3), .i_valid(v3),
        .o_ready(r3), .o_data(od3), .o_field(of3), .o_eop(oe3),
        .o_valid(ov3), .i_ready(ir3)
    );

    ct_stream_arb #(.NI(2), .WD(8)) u_dut2 (
        .clk(clk), .reset(reset), .i_data(d2), .i_eop(e2), .i_valid(v2),
        .o_ready(r2), .o_data(od2), .o_field(of2), .o_eop(oe2),
        .o_valid(ov2), .i_ready(ir2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        d3 = '0; e3 = '0; v3 = '0; ir3 = 1'b1;
        d2 = '0; e2 = '0; v2 = '0; ir2 = 1'b1;
        #2;
        chk("rst_ov3", 32'(ov3), 0);
        chk("rst_r3",  32'(r3),  0);
        chk("rst_ov2", 32'(ov2), 0);
        chk("rst_r2",  32'(r2),  0);
        tick();
        tick();
        reset = 1'b1;
        tick();

`ifdef CT_STREAM_ARB_OREG_EN
        begin
            int n_in  = 0;
            int n_out = 0;
            logic exp_f = 1'b0;
            logic [1:0] r_hold;
            d2 = {8'hB1, 8'hA0};
            v2 = 2'b11;
            e2 = 2'b11;
            for (int c = 0; c < 12; c++) begin
                ir2 = (c % 2 == 0);
                #2;
                if (c == 0) chk("oreg_lat", 32'(ov2), 0);
                r_hold = r2;
                ir2 = ~ir2;
                #1;
                chk("oreg_rdy_indep", 32'(r2), 32'(r_hold));
                ir2 = ~ir2;
                #1;
                if ((r2 & v2) != 2'b00) n_in++;
                if (ov2 && ir2) begin
                    chk("oreg_field", 32'(of2), 32'(exp_f));
                    chk("oreg_data", 32'(od2), exp_f ? 32'hB1 : 32'hA0);
                    exp_f = ~exp_f;
                    n_out++;
                end
                tick();
            end
            v2 = 2'b00;
            ir2 = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #2;
                if (ov2 && ir2) begin
                    chk("oreg_drain_field", 32'(of2), 32'(exp_f));
                    exp_f = ~exp_f;
                    n_out++;
                end
                tick();
            end
            chk("oreg_in_nonzero", 32'(n_in != 0), 1);
            chk("oreg_no_loss", 32'(n_out), 32'(n_in));
        end
`else
        // T1: NI=3 single-beat packets rotate 0,1,2
        d3 = {8'h22, 8'h11, 8'h00};
        v3 = 3'b111;
        e3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("t1_field", 32'(of3), 32'(k));
            chk("t1_ready", 32'(r3), 32'(1 << k));
            chk("t1_data",  32'(od3), 32'(8'h11 * k));
            tick();
        end
        v3 = 3'b000;

        // T2: move last to 0 with a lone beat from input 0
        d2 = {8'hB0, 8'hA0};
        v2 = 2'b01;
        e2 = 2'b01;
        #2;
        chk("t2_pre_field", 32'(of2), 0);
        tick();
        // input 1 four-beat packet while input 0 keeps requesting
        for (int k = 0; k < 4; k++) begin
            v2 = 2'b11;
            e2 = {(k == 3), 1'b1};
            d2 = {8'hB0 + 8'(k), 8'hA0};
            #2;
            chk("t2_field", 32'(of2), 1);
            chk("t2_ready", 32'(r2), 2);
            chk("t2_valid", 32'(ov2), 1);
            chk("t2_data",  32'(od2), 32'(8'hB0 + k));
            chk("t2_eop",   32'(oe2), 32'(k == 3));
            tick();
        end
        e2 = 2'b01;
        #2;
        chk("t2_after_field", 32'(of2), 0);
        chk("t2_after_ready", 32'(r2), 1);
        tick();
        v2 = 2'b00;

        // T3: lock on input 0, it drops for 2 cycles while input 1 requests
        v2 = 2'b01;
        e2 = 2'b00;
        #2;
        chk("t3_start_field", 32'(of2), 0);
        chk("t3_start_ready", 32'(r2), 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            v2 = 2'b10;
            e2 = 2'b10;
            #2;
            chk("t3_bubble_valid", 32'(ov2), 0);
            chk("t3_bubble_r1",    32'(r2[1]), 0);
            chk("t3_bubble_field", 32'(of2), 0);
            tick();
        end
        v2 = 2'b11;
        e2 = 2'b11;
        d2 = {8'hB7, 8'hA5};
        #2;
        chk("t3_eop_field", 32'(of2), 0);
        chk("t3_eop_valid", 32'(ov2), 1);
        chk("t3_eop_data",  32'(od2), 32'hA5);
        tick();
        v2 = 2'b10;
        #2;
        chk("t3_next_field", 32'(of2), 1);
        chk("t3_next_data",  32'(od2), 32'hB7);
        tick();
        v2 = 2'b00;

        // T4: downstream stalled 5 cycles with inputs 0 and 1 valid
        ir2 = 1'b0;
        v2 = 2'b11;
        e2 = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t4_stall_field", 32'(of2), 0);
            chk("t4_stall_ready", 32'(r2), 0);
            chk("t4_stall_valid", 32'(ov2), 1);
            tick();
        end
        chk("t4_last", 32'(u_dut2.r_last), 1);
        ir2 = 1'b1;
        #2;
        chk("t4_rel_field", 32'(of2), 0);
        chk("t4_rel_ready", 32'(r2), 1);
        tick();
        #2;
        chk("t4_rel2_field", 32'(of2), 1);
        chk("t4_rel2_ready", 32'(r2), 2);
        tick();
        v2 = 2'b00;

        // T5: NI=3, reset mid-packet on input 2
        v3 = 3'b100;
        e3 = 3'b000;
        #2;
        chk("t5_field", 32'(of3), 2);
        tick();
        #2;
        chk("t5_lock_field", 32'(of3), 2);
        tick();
        v3 = 3'b101;
        e3 = 3'b001;
        reset = 1'b0;
        #2;
        chk("t5_rst_valid", 32'(ov3), 0);
        chk("t5_rst_ready", 32'(r3), 0);
        tick();
        reset = 1'b1;
        #2;
        chk("t5_post_field", 32'(of3), 0);
        chk("t5_post_valid", 32'(ov3), 1);
        chk("t5_post_ready", 32'(r3), 1);
        tick();
        v3 = 3'b100;
        e3 = 3'b100;
        #2;
        chk("t5_next_field", 32'(of3), 2);
        chk("t5_next_valid", 32'(ov3), 1);
        tick();
        v3 = 3'b000;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
